// File: rtl/sme_driver.sv
// Host-side driver for a string-matching engine: buffers one string or pattern
// frame, replays it to the SME one character per cycle, then collects the result.
module sme_driver #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic       busy
);

  localparam int BUF_N = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
  localparam int AW    = $clog2(BUF_N);
  localparam int LW    = $clog2(BUF_N + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, RESULT} state_t;

  state_t          state_q, state_d;
  logic            kind_q, kind_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic [10:0]     cnt_q, cnt_d;
  logic [7:0]      chardata_q, chardata_d;
  logic            isstring_q, isstring_d;
  logic            ispattern_q, ispattern_d;
  logic            res_valid_q, res_valid_d;
  logic            res_match_q, res_match_d;
  logic [4:0]      res_index_q, res_index_d;
  logic            res_timeout_q, res_timeout_d;

  logic [7:0]      mem [BUF_N];
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [LW-1:0]   lim;
  logic            accept;

  assign in_ready    = (state_q == IDLE) || (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign accept      = in_valid && in_ready;
  assign chardata    = chardata_q;
  assign isstring    = isstring_q;
  assign ispattern   = ispattern_q;
  assign res_valid   = res_valid_q;
  assign res_match   = res_match_q;
  assign res_index   = res_index_q;
  assign res_timeout = res_timeout_q;

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    len_d         = len_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    chardata_d    = 8'h00;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    res_valid_d   = res_valid_q;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    wr_en         = 1'b0;
    wr_addr       = len_q[AW-1:0];
    lim           = kind_q ? LW'(PAT_MAX) : LW'(STR_MAX);

    case (state_q)
      IDLE: begin
        if (accept) begin
          kind_d  = in_kind;
          wr_en   = 1'b1;
          wr_addr = '0;
          len_d   = LW'(1);
          if (in_last) begin
            // Single-character frame: the character bypasses the buffer onto the bus.
            state_d     = SEND;
            idx_d       = LW'(1);
            chardata_d  = in_data;
            isstring_d  = ~in_kind;
            ispattern_d = in_kind;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          if (len_q < lim) begin
            wr_en = 1'b1;
            len_d = len_q + 1'b1;
          end
          if (in_last) begin
            state_d     = SEND;
            idx_d       = LW'(1);
            chardata_d  = mem[0];
            isstring_d  = ~kind_q;
            ispattern_d = kind_q;
          end
        end
      end
      SEND: begin
        if (idx_q == len_q) begin
          state_d = kind_q ? WAIT : IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          len_d   = '0;
        end else begin
          chardata_d  = mem[idx_q[AW-1:0]];
          isstring_d  = ~kind_q;
          ispattern_d = kind_q;
          idx_d       = idx_q + 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 11'd1;
        // A real SME answer takes priority over the timeout in the same cycle.
        if (sme_valid) begin
          state_d       = RESULT;
          res_valid_d   = 1'b1;
          res_match_d   = sme_match;
          res_index_d   = sme_match ? sme_index : 5'd0;
          res_timeout_d = 1'b0;
        end else if (cnt_q == 11'(TIMEOUT - 1)) begin
          state_d       = RESULT;
          res_valid_d   = 1'b1;
          res_match_d   = 1'b0;
          res_index_d   = 5'd0;
          res_timeout_d = 1'b1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d       = IDLE;
          res_valid_d   = 1'b0;
          res_match_d   = 1'b0;
          res_index_d   = 5'd0;
          res_timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      kind_q        <= 1'b0;
      len_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      chardata_q    <= 8'h00;
      isstring_q    <= 1'b0;
      ispattern_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= 5'd0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      chardata_q    <= chardata_d;
      isstring_q    <= isstring_d;
      ispattern_q   <= ispattern_d;
      res_valid_q   <= res_valid_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  // Frame buffer holds data only; its contents are irrelevant after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_data;
  end

endmodule

// File: doc/sme_driver.md
SME_DRIVER -- requirements
Module: sme_driver

Interface
REQ-001 Parameter STR_MAX, 32, maximum characters per string frame.
REQ-002 Parameter PAT_MAX, 8, maximum characters per pattern frame.
REQ-003 Parameter TIMEOUT, 1024, WAIT cycles before giving up on SME valid.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  host character valid.
REQ-007 in_ready  output  1  driver accepts a host character this cycle.
REQ-008 in_data  input  8  host character (ASCII).
REQ-009 in_kind  input  1  frame type: 0 = string, 1 = pattern; sampled on the first character of a frame.
REQ-010 in_last  input  1  last character of the frame.
REQ-011 chardata  output  8  character to SME.
REQ-012 isstring  output  1  chardata is a string character.
REQ-013 ispattern  output  1  chardata is a pattern character.
REQ-014 sme_valid  input  1  SME result valid.
REQ-015 sme_match  input  1  SME match flag.
REQ-016 sme_index  input  5  SME match index.
REQ-017 res_valid  output  1  result available to host.
REQ-018 res_ready  input  1  host consumes result.
REQ-019 res_match  output  1  captured match, 0 on timeout.
REQ-020 res_index  output  5  captured index, 0 on timeout or no match.
REQ-021 res_timeout  output  1  result produced by timeout.
REQ-022 busy  output  1  high in every state except IDLE.

Function
REQ-023 FSM states SHALL be IDLE, LOAD, SEND, WAIT, RESULT.
REQ-024 Handshake: a character transfers on rising edge with in_valid & in_ready; in_ready SHALL be 1 only in IDLE and LOAD.
REQ-025 IDLE: first accepted character SHALL latch in_kind into frame kind, store at buffer[0], set length 1, go to LOAD (or to SEND if in_last).
REQ-026 LOAD: each accepted character SHALL be stored at buffer[length] and length incremented; in_kind ignored.
REQ-027 Characters beyond the frame limit (STR_MAX for string, PAT_MAX for pattern) SHALL be accepted and discarded; length saturates at the limit.
REQ-028 Accepting in_last SHALL move to SEND on the next cycle; no further characters accepted until IDLE.
REQ-029 SEND: for exactly length consecutive cycles, chardata = buffer[i] (i = 0..length-1) with isstring = ~kind, ispattern = kind; no gaps.
REQ-030 If in_last is accepted at edge N, the first character SHALL be driven from edge N to edge N+1 and the last from edge N+length-1 to N+length.
REQ-031 After the last string character SHALL go to IDLE; after the last pattern character SHALL go to WAIT.
REQ-032 Outside SEND, chardata SHALL be 8'h00 and isstring = ispattern = 0.
REQ-033 WAIT: 11-bit counter cleared on entry, incremented each cycle; sme_valid high at an edge SHALL capture sme_match, sme_index, clear res_timeout, go to RESULT.
REQ-034 If counter reaches TIMEOUT-1 without sme_valid, SHALL go to RESULT with res_match=0, res_index=0, res_timeout=1.
REQ-035 sme_valid and timeout in the same cycle: sme_valid SHALL win.
REQ-036 sme_valid outside WAIT SHALL be ignored.
REQ-037 RESULT: res_valid=1 and result fields stable until res_ready high at an edge, then IDLE; res_valid SHALL assert one cycle after the capturing edge.
REQ-038 A pattern frame with no preceding string SHALL still be sent; ordering is the host's responsibility.

Reset
REQ-039 reset low SHALL asynchronously force IDLE, length 0, counter 0, chardata 0, isstring 0, ispattern 0, res_valid 0, res_match 0, res_index 0, res_timeout 0, busy 0; in_ready 1 after release.
REQ-040 reset mid-SEND or mid-WAIT SHALL abort the frame; no result produced; buffer contents are don't-care.

Verification
REQ-041 String "abcd" (kind 0, last on 'd') -> 4 consecutive cycles isstring=1 chardata 61,62,63,64, then IDLE, no res_valid.
REQ-042 Pattern "bc" after that string, SME returns valid with match=1 index=1 after 5 WAIT cycles -> ispattern=1 for 2 cycles, res_valid=1, res_match=1, res_index=1, res_timeout=0, held until res_ready.
REQ-043 Pattern of 10 characters -> only first 8 sent (ispattern high exactly 8 cycles), remaining 2 accepted and dropped.
REQ-044 Pattern with SME never asserting valid -> res_valid after 1024 WAIT cycles with res_timeout=1, res_match=0, res_index=0.
REQ-045 sme_valid asserted in the final timeout cycle with match=1 index=7 -> res_timeout=0, res_match=1, res_index=7.
REQ-046 reset low during SEND of a 32-char string -> outputs zero immediately; after release, new 1-char pattern frame sent correctly.
